// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmit serializer.
// All outputs are registered; the head word is presented one clock after it is written.
module uart_tx_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 4,
  parameter int PROG_FULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] iv_din,
  output logic                  o_full,
  output logic                  o_prog_full,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] ov_dout,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   ov_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  empty_q, full_q, prog_full_q, ovf_q, unf_q;
  logic                  rd_acc, wr_acc;

  always_comb begin
    rd_acc   = i_rd & ~empty_q;
    wr_acc   = i_wr & (~full_q | rd_acc);
    wr_ptr_d = wr_ptr_q + (ADDR_WIDTH+1)'(wr_acc);
    rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(rd_acc);
    count_d  = wr_ptr_d - rd_ptr_d;
    dout_d   = dout_q;
    // The next head is the word being written this cycle when the FIFO
    // would otherwise be empty; the memory write has not landed yet.
    if (wr_ptr_d != rd_ptr_d) begin
      if (wr_acc && (rd_ptr_d == wr_ptr_q)) dout_d = iv_din;
      else                                  dout_d = mem_q[rd_ptr_d[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= iv_din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      prog_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      empty_q     <= (wr_ptr_d == rd_ptr_d);
      full_q      <= (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
      prog_full_q <= (count_d >= (ADDR_WIDTH+1)'(PROG_FULL_THRESH));
      ovf_q       <= i_wr & ~wr_acc;
      unf_q       <= i_rd & empty_q;
    end
  end

  assign o_full      = full_q;
  assign o_prog_full = prog_full_q;
  assign ov_dout     = dout_q;
  assign o_empty     = empty_q;
  assign ov_count    = count_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_wr = 1'b0, i_rd = 1'b0;
  logic [7:0] iv_din = 8'h00;
  logic       o_full, o_prog_full, o_empty, o_overflow, o_underflow;
  logic [7:0] ov_dout;
  logic [4:0] ov_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  uart_tx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .PROG_FULL_THRESH(12)) dut (
    .clk(clk), .reset_n(reset_n), .i_wr(i_wr), .iv_din(iv_din),
    .o_full(o_full), .o_prog_full(o_prog_full), .i_rd(i_rd),
    .ov_dout(ov_dout), .o_empty(o_empty), .ov_count(ov_count),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of stored bytes
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_ovf, m_unf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_dout <= 8'h00;
      m_ovf  <= 1'b0;
      m_unf  <= 1'b0;
    end else begin
      automatic bit rd_ok = i_rd && (q.size() > 0);
      automatic bit wr_ok = i_wr && ((q.size() < 16) || rd_ok);
      m_ovf <= i_wr && !wr_ok;
      m_unf <= i_rd && (q.size() == 0);
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(iv_din);
      if (q.size() > 0) m_dout <= q[0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count", 32'(ov_count), 32'(q.size()));
      chk("m_empty", 32'(o_empty), 32'(q.size() == 0));
      chk("m_full",  32'(o_full),  32'(q.size() == 16));
      chk("m_prog",  32'(o_prog_full), 32'(q.size() >= 12));
      chk("m_dout",  32'(ov_dout), 32'(m_dout));
      chk("m_ovf",   32'(o_overflow), 32'(m_ovf));
      chk("m_unf",   32'(o_underflow), 32'(m_unf));
    end
  end

  // One clock: drive inputs, take the edge, settle 1ns, release requests
  task automatic cyc(input bit wr, input logic [7:0] d, input bit rd);
    i_wr = wr; iv_din = d; i_rd = rd;
    @(posedge clk);
    #1;
    i_wr = 1'b0; i_rd = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full",  32'(o_full), 32'd0);
    chk("rst_count", 32'(ov_count), 32'd0);
    chk("rst_dout",  32'(ov_dout), 32'h00);
    cyc(0, 8'h00, 0);
    chk("idle_ovf", 32'(o_overflow), 32'd0);
    chk("idle_unf", 32'(o_underflow), 32'd0);

    // FWFT latency
    cyc(1, 8'hA5, 0);
    chk("fwft_empty", 32'(o_empty), 32'd0);
    chk("fwft_dout",  32'(ov_dout), 32'hA5);
    chk("fwft_count", 32'(ov_count), 32'd1);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 1);
    chk("fwft_pop_empty", 32'(o_empty), 32'd1);
    chk("fwft_pop_count", 32'(ov_count), 32'd0);

    // Fill/drain three times to wrap the pointers
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin
        cyc(1, 8'(i), 0);
        chk("fill_prog", 32'(o_prog_full), 32'(i + 1 >= 12));
      end
      chk("fill_full",  32'(o_full), 32'd1);
      chk("fill_count", 32'(ov_count), 32'd16);
      cyc(1, 8'hEE, 0);
      chk("ovf_pulse", 32'(o_overflow), 32'd1);
      chk("ovf_count", 32'(ov_count), 32'd16);
      cyc(0, 8'h00, 0);
      chk("ovf_clear", 32'(o_overflow), 32'd0);
      for (int i = 0; i < 16; i++) begin
        chk("drain_dout", 32'(ov_dout), 32'(i));
        cyc(0, 8'h00, 1);
      end
      chk("drain_empty", 32'(o_empty), 32'd1);
    end

    // Simultaneous read and write at full
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0);
    cyc(1, 8'h55, 1);
    chk("sim_count", 32'(ov_count), 32'd16);
    chk("sim_ovf",   32'(o_overflow), 32'd0);
    chk("sim_full",  32'(o_full), 32'd1);
    for (int i = 1; i < 16; i++) begin
      chk("sim_dout", 32'(ov_dout), 32'(8'h20 + i));
      cyc(0, 8'h00, 1);
    end
    chk("sim_last", 32'(ov_dout), 32'h55);
    cyc(0, 8'h00, 1);
    chk("sim_empty", 32'(o_empty), 32'd1);

    // Underflow with a same-cycle write
    cyc(1, 8'h3C, 1);
    chk("unf_pulse", 32'(o_underflow), 32'd1);
    chk("unf_count", 32'(ov_count), 32'd1);
    chk("unf_dout",  32'(ov_dout), 32'h3C);
    cyc(0, 8'h00, 0);
    chk("unf_clear", 32'(o_underflow), 32'd0);
    cyc(0, 8'h00, 1);

    // Asynchronous reset between edges
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h70 + i), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_empty", 32'(o_empty), 32'd1);
    chk("arst_count", 32'(ov_count), 32'd0);
    chk("arst_dout",  32'(ov_dout), 32'h00);
    i_wr = 1'b1; iv_din = 8'hBB;
    @(posedge clk);
    #1 i_wr = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk("arst_hold", 32'(ov_count), 32'd0);
    cyc(1, 8'h11, 0);
    chk("arst_wr_dout",  32'(ov_dout), 32'h11);
    chk("arst_wr_count", 32'(ov_count), 32'd1);

    // Randomized traffic in phases biased toward filling or draining
    for (int p = 0; p < 16; p++) begin
      automatic int pw = (p % 4 == 0) ? 85 : (p % 4 == 1) ? 20 : (p % 4 == 2) ? 50 : 95;
      automatic int pr = (p % 4 == 0) ? 30 : (p % 4 == 1) ? 90 : (p % 4 == 2) ? 50 : 60;
      for (int c = 0; c < 150; c++)
        cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
